// File: rtl/prio_index_decoder.sv
// -----------------------------------------------------------------------------
// prio_index_decoder
//
// Buffered one-hot decoder for the encoded request link. The producer hands
// over {in_none, in_idx} entries through a valid/ready handshake. Entries are
// queued in a DEPTH-entry FIFO. The head entry is presented downstream as a
// one-hot vector through a second valid/ready handshake.
//
// Parameters
//   IDX_W   encoded index width; OUT_W = 2**IDX_W one-hot output width
//   DEPTH   FIFO entries, power of two and >= 2
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset, flushes the FIFO
//   in_idx       encoded index of the offered entry
//   in_none      offered entry carries no request (decodes to all-zero)
//   in_valid     producer offers an entry
//   in_ready     FIFO has room (registered count only, no pass-through)
//   out_onehot   decoded head entry, zero when empty or head is "none"
//   out_valid    head entry present
//   out_ready    consumer takes the head entry
//   pending      sticky OR of consumed vectors     (PENDING_VEC_EN only)
//   clr_pending  clears pending, same-cycle pop wins (PENDING_VEC_EN only)
//
// Build option
//   PENDING_VEC_EN  when defined, adds the pending register and the
//                   pending/clr_pending ports. When undefined, no extra flops.
// -----------------------------------------------------------------------------

// One output line of the decoder: fires when the head entry is present, is a
// real request and its index matches this lane.
module prio_dec_lane #(
  parameter int IDX_W = 3,
  parameter int LANE  = 0
) (
  input  logic             vld_i,
  input  logic             none_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             hit_o
);
  assign hit_o = vld_i & ~none_i & (idx_i == IDX_W'(LANE));
endmodule

module prio_index_decoder #(
  parameter  int IDX_W = 3,
  parameter  int DEPTH = 2,
  localparam int OUT_W = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_none,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PENDING_VEC_EN
  ,
  output logic [OUT_W-1:0] pending,
  input  logic             clr_pending
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             none;
    logic [IDX_W-1:0] idx;
  } entry_t;

  // Storage has no reset; occupancy is tracked by cnt_q, so stale contents
  // are never visible after a reset flush.
  entry_t           mem_q [DEPTH];
  entry_t           wr_ent;
  entry_t           head;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // Handshakes depend on registered count only: a pop in the same cycle as
  // a full FIFO does not open in_ready, keeping in->out free of comb paths.
  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_ent.none = in_none;
  assign wr_ent.idx  = in_idx;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_ent;
  end

  // Decode of the registered head entry, one lane per output line.
  assign head = mem_q[rd_ptr_q];

  for (genvar g = 0; g < OUT_W; g++) begin : g_lane
    prio_dec_lane #(
      .IDX_W (IDX_W),
      .LANE  (g)
    ) u_lane (
      .vld_i  (out_valid),
      .none_i (head.none),
      .idx_i  (head.idx),
      .hit_o  (out_onehot[g])
    );
  end

`ifdef PENDING_VEC_EN
  logic [OUT_W-1:0] pending_q, pending_d;

  // Clear is applied first so bits consumed in the clearing cycle survive.
  always_comb begin
    pending_d = clr_pending ? '0 : pending_q;
    if (pop) pending_d = pending_d | out_onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;
`endif

endmodule

// File: doc/prio_index_decoder.md
# prio_index_decoder

- Buffered decoder for the compressed request stream produced by the team's 8→3 priority encoder.
- Accepts an encoded index (plus a "no request" flag) through a valid/ready handshake and queues it in a small FIFO.
- Presents each queued entry as a one-hot vector through a second valid/ready handshake.
- Sits at the consumer end of an encoded-request link, restoring the one-hot line selects that the encoder compressed.

## Interface
Parameters:
- IDX_W, 3: index width; OUT_W = 2**IDX_W (8 by default).
- DEPTH, 2: FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_idx  input  IDX_W  encoded index.
- in_none  input  1  entry carries no request; decodes to all-zero (mirror of encoder valid=0).
- in_valid  input  1  producer has an entry.
- in_ready  output  1  FIFO can accept an entry.
- out_onehot  output  OUT_W  decoded head entry.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer takes the head entry.
- pending  output  OUT_W  sticky OR of consumed vectors (PENDING_VEC_EN only).
- clr_pending  input  1  clears pending (PENDING_VEC_EN only).

## Operation
- Push when in_valid && in_ready.
  - Stores {in_none, in_idx} at wr_ptr; wr_ptr increments.
- Pop when out_valid && out_ready; rd_ptr increments.
- Pointers are log2(DEPTH) bits and wrap naturally.
- count is log2(DEPTH)+1 bits:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- in_ready = (count != DEPTH), combinational from registered count.
  - No pass-through when full: a pop in the same cycle does not free space.
- out_valid = (count != 0).
- out_onehot:
  - Empty: 0.
  - Head in_none=1: 0 (out_valid still 1).
  - Otherwise: 1 << head idx; exactly one bit set.
- Producer must hold in_idx/in_none/in_valid stable until accepted.
- The block never drops or reorders entries.
- in_valid while full: entry is held off and no state changes.
- All IDX_W index values are legal; there is no error case.
- Reset, including mid-transfer: FIFO is emptied and any buffered entries are discarded.
  - count=0, pointers=0, out_valid=0, out_onehot=0, in_ready=1.
  - pending=0.

## Timing
- Latency: entry pushed at edge N appears on out_* after edge N (cycle N+1). No combinational input→output path.
- Throughput: one push and one pop per cycle when 0<count<DEPTH.
- Full at DEPTH: in_ready=0 until the cycle after a pop.
- Empty: a push and a pop cannot occur in the same cycle (out_valid=0).
- out_onehot/out_valid change only on clock edges or reset. They are stable while out_valid && !out_ready.

## Configuration
Macro PENDING_VEC_EN controls the pending vector.

Defined:
- pending register and clr_pending port exist.
- Each edge: pending <= (clr_pending ? 0 : pending) | (pop ? out_onehot : 0).
- A pop in the same cycle as clr_pending leaves only the popped bits set.
- Reset value 0.

Undefined:
- pending and clr_pending ports are absent.
- No extra flops; the datapath is otherwise identical.

## Test plan
- Reset then single push idx=5, out_ready=1 → out_valid=1 with out_onehot=8'h20 one cycle later; popped next edge; out_valid=0 after.
- Push idx=3 with in_none=1 → out_valid=1, out_onehot=8'h00.
- out_ready=0; push 0, 7, then in_valid=1 with idx=2 → in_ready=0 after 2nd push, idx=2 held. Raise out_ready → outputs 8'h01, 8'h80, 8'h04 in order; no loss.
- Continuous push idx 0..7 with out_ready=1 → one output per cycle, 8'h01..8'h80 in order, 1-cycle latency, count stays 1.
- Assert rst_n low mid-stream with count=2 → all outputs 0, in_ready=1 immediately; the next pushed entry is the first popped.
- PENDING_VEC_EN: pop idx 1 then 6 → pending=8'h42. clr_pending together with pop of idx 0 → pending=8'h01. Without the macro, the build contains no pending port.
